// File: rtl/ppi_pkg.sv
// Shared types, helper functions and default-derived sizes for the
// time-multiplexed polyphase interpolator.
package ppi_pkg;

    // Ceiling division for positive operands.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 32'd1) / b;
    endfunction

    // Bits needed to index n items (0 for n <= 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) == 0) ? 32'd1 : clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Sizes at the default configuration.
    localparam int unsigned PPI_IDATA_W = 8;
    localparam int unsigned PPI_M       = 4;
    localparam int unsigned PPI_L       = 12;
    localparam int unsigned PPI_COEFF_W = 16;
    localparam int unsigned PPI_C       = ceil_div(PPI_L, PPI_M);
    localparam int unsigned PPI_ADDR_W  = idx_width(PPI_L);
    localparam int unsigned PPI_PHASE_W = idx_width(PPI_M);
    localparam int unsigned PPI_ODATA_W = PPI_IDATA_W + PPI_COEFF_W + PPI_C;

endpackage

// File: rtl/ppi_coeff_bank.sv
// Runtime-loadable coefficient register file.
//   clk/rst  : clock, synchronous active-high reset (clears all entries)
//   we/waddr/wdata : write port, entries >= L are never written
//   raddr/rdata    : combinational read, indices >= L read as 0
module ppi_coeff_bank #(
    parameter int unsigned L      = 12,
    parameter int unsigned CW     = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned RAW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic [RAW-1:0] raddr,
    output logic [CW-1:0] rdata
);

    logic [CW-1:0] mem_q [L];
    logic [CW-1:0] mem_d [L];

    // Decoded write; an address with no matching entry falls through.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < int'(L); i++) begin
            if (we && (waddr == AW'(i))) mem_d[i] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(L); i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read mux; the read index may span past L because C*M can exceed L.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(L); i++) begin
            if (raddr == RAW'(i)) rdata = mem_q[i];
        end
    end

endmodule

// File: rtl/ppi_tdm_mac.sv
// Time-multiplexed polyphase interpolator: one multiplier and accumulator
// produce the M phase outputs of each input sample serially.
//   i_clk, i_rst (sync, active-high), i_ena (global freeze when low)
//   i_valid/o_ready/i_data                  : input sample handshake
//   i_coeff_we/i_coeff_addr/i_coeff_data    : coefficient load (IDLE only)
//   o_valid/i_ready/o_data/o_phase/o_last   : output phase handshake
module ppi_tdm_mac
    import ppi_pkg::*;
#(
    parameter  int unsigned gp_idata_width          = 8,
    parameter  int unsigned gp_interpolation_factor = 4,
    parameter  int unsigned gp_coeff_length         = 12,
    parameter  int unsigned gp_coeff_width          = 16,
    localparam int unsigned gp_odata_width = gp_idata_width + gp_coeff_width
                                           + ceil_div(gp_coeff_length, gp_interpolation_factor),
    localparam int unsigned ADDR_W  = idx_width(gp_coeff_length),
    localparam int unsigned PHASE_W = idx_width(gp_interpolation_factor)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ena,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [gp_idata_width-1:0] i_data,
    input  logic                      i_coeff_we,
    input  logic [ADDR_W-1:0]         i_coeff_addr,
    input  logic [gp_coeff_width-1:0] i_coeff_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [gp_odata_width-1:0] o_data,
    output logic [PHASE_W-1:0]        o_phase,
    output logic                      o_last
);

    localparam int unsigned M      = gp_interpolation_factor;
    localparam int unsigned C      = ceil_div(gp_coeff_length, M);
    localparam int unsigned TAP_W  = idx_width(C);
    localparam int unsigned RIDX_W = idx_width(C * M);
    localparam int unsigned PROD_W = gp_idata_width + gp_coeff_width;
    localparam int unsigned OW     = gp_odata_width;

    state_e                            state_q, state_d;
    logic        [PHASE_W-1:0]         phase_q, phase_d;
    logic        [TAP_W-1:0]           tap_q, tap_d;
    logic signed [OW-1:0]              acc_q, acc_d;
    logic signed [gp_idata_width-1:0]  x_q [C];
    logic signed [gp_idata_width-1:0]  x_d [C];
    logic signed [OW-1:0]              o_data_q, o_data_d;
    logic        [PHASE_W-1:0]         o_phase_q, o_phase_d;
    logic                              o_last_q, o_last_d;
    logic                              o_valid_q, o_valid_d;
    logic                              o_ready_q, o_ready_d;

    logic                              coeff_we_c;
    logic        [RIDX_W-1:0]          rd_idx_c;
    logic signed [gp_coeff_width-1:0]  h_rd_c;
    logic signed [gp_idata_width-1:0]  x_sel_c;
    logic signed [PROD_W-1:0]          prod_c;
    logic signed [OW-1:0]              acc_sum_c;

    ppi_coeff_bank #(
        .L   (gp_coeff_length),
        .CW  (gp_coeff_width),
        .AW  (ADDR_W),
        .RAW (RIDX_W)
    ) u_coeff_bank (
        .clk   (i_clk),
        .rst   (i_rst),
        .we    (coeff_we_c),
        .waddr (i_coeff_addr),
        .wdata (i_coeff_data),
        .raddr (rd_idx_c),
        .rdata (h_rd_c)
    );

    // MAC datapath: h[tap*M + phase] * x[tap] added to the running sum.
    always_comb begin
        rd_idx_c = RIDX_W'(tap_q) * RIDX_W'(M) + RIDX_W'(phase_q);
        x_sel_c  = '0;
        for (int k = 0; k < int'(C); k++) begin
            if (tap_q == TAP_W'(k)) x_sel_c = x_q[k];
        end
        prod_c    = PROD_W'(h_rd_c) * PROD_W'(x_sel_c);
        acc_sum_c = acc_q + OW'(prod_c);
    end

    // Next-state and output logic; everything holds unless i_ena is high.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        x_d        = x_q;
        o_data_d   = o_data_q;
        o_phase_d  = o_phase_q;
        o_last_d   = o_last_q;
        o_valid_d  = o_valid_q;
        o_ready_d  = o_ready_q;
        coeff_we_c = 1'b0;

        if (i_ena) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Coefficients change only between samples.
                    coeff_we_c = i_coeff_we;
                    if (i_valid && o_ready_q) begin
                        x_d[0] = i_data;
                        for (int k = 1; k < int'(C); k++) x_d[k] = x_q[k-1];
                        phase_d   = '0;
                        tap_d     = '0;
                        acc_d     = '0;
                        o_ready_d = 1'b0;
                        state_d   = ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (tap_q == TAP_W'(C - 1)) begin
                        o_data_d  = acc_sum_c;
                        o_phase_d = phase_q;
                        o_last_d  = (phase_q == PHASE_W'(M - 1));
                        o_valid_d = 1'b1;
                        state_d   = ST_OUT;
                    end else begin
                        acc_d = acc_sum_c;
                        tap_d = tap_q + TAP_W'(1);
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        o_valid_d = 1'b0;
                        if (phase_q == PHASE_W'(M - 1)) begin
                            o_ready_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            phase_d = phase_q + PHASE_W'(1);
                            tap_d   = '0;
                            acc_d   = '0;
                            state_d = ST_MAC;
                        end
                    end
                end
                default: begin
                    o_valid_d = 1'b0;
                    o_ready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            tap_q     <= '0;
            acc_q     <= '0;
            for (int k = 0; k < int'(C); k++) x_q[k] <= '0;
            o_data_q  <= '0;
            o_phase_q <= '0;
            o_last_q  <= 1'b0;
            o_valid_q <= 1'b0;
            o_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            tap_q     <= tap_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            o_data_q  <= o_data_d;
            o_phase_q <= o_phase_d;
            o_last_q  <= o_last_d;
            o_valid_q <= o_valid_d;
            o_ready_q <= o_ready_d;
        end
    end

    assign o_ready = o_ready_q;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_phase = o_phase_q;
    assign o_last  = o_last_q;

endmodule
